// File: rtl/watch_multimode.sv
// Multimode watch: BCD HH:MM:SS clock with set modes plus an MM:SS countdown timer.
// Optional alarm (SET_AH/SET_AM states, alarm_ring) is compiled in by WATCH_MULTIMODE_ALARM_EN.
module watch_multimode #(
  parameter int MAX_HOUR      = 23,
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_tick,
  input  logic       pulse_blink,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  input  logic       start_button,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       timer_done,
  output logic       alarm_ring
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] HOUR_TOP = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};
  localparam logic [7:0] MS_TOP = 8'h59;
  localparam logic [5:0] SEP = 6'b000001;

  typedef enum logic [2:0] {
    RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3, SET_AH = 3'd4, SET_AM = 3'd5, TMR = 3'd6
  } state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00) return top;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [5:0] digit(input logic en, input logic [3:0] v);
    return {en, v, 1'b0};
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d, tm_q, tm_d, ts_q, ts_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          run_q, run_d, done_q, done_d, ring_q, ring_d;
  logic [47:0]   disp_q, disp_d;
  logic          sec_s, en_h_s, en_m_s, en_s_s, en_t_s;
`ifdef WATCH_MULTIMODE_ALARM_EN
  logic [7:0]    ah_q, ah_d, am_q, am_d;
  logic          armed_q, armed_d, btn_s, clear_s, match_s;
`endif

  // Next state of every counter plus the display image of the current state.
  always_comb begin
    state_d = state_q;
    hh_d = hh_q; mm_d = mm_q; ss_d = ss_q; tm_d = tm_q; ts_d = ts_q;
    pre_d = pre_q; run_d = run_q; done_d = 1'b0; ring_d = 1'b0; sec_s = 1'b0;
`ifdef WATCH_MULTIMODE_ALARM_EN
    ah_d = ah_q; am_d = am_q;
`endif
    if (state_q == RUN || state_q == TMR) begin
      if (pulse_tick && pre_q == PRE_LAST) begin
        pre_d = {PW{1'b0}};
        sec_s = 1'b1;
      end else if (pulse_tick) pre_d = pre_q + PW'(1);
      else pre_d = pre_q;
    end else begin
      pre_d = {PW{1'b0}};
    end

    if (sec_s) begin
      ss_d = bcd_inc(ss_q, MS_TOP);
      mm_d = (ss_q == MS_TOP) ? bcd_inc(mm_q, MS_TOP) : mm_q;
      hh_d = (ss_q == MS_TOP && mm_q == MS_TOP) ? bcd_inc(hh_q, HOUR_TOP) : hh_q;
    end else begin
      ss_d = ss_q;
    end

    // mode wins over the other buttons; add together with sub cancels out
    if (mode_button) begin
      case (state_q)
        RUN:    state_d = SET_H;
        SET_H:  state_d = SET_M;
        SET_M:  state_d = SET_S;
`ifdef WATCH_MULTIMODE_ALARM_EN
        SET_S:  state_d = SET_AH;
`else
        SET_S:  state_d = TMR;
`endif
        SET_AH: state_d = SET_AM;
        SET_AM: state_d = TMR;
        TMR:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end else begin
      if (add_button != sub_button) begin
        case (state_q)
          SET_H: hh_d = add_button ? bcd_inc(hh_q, HOUR_TOP) : bcd_dec(hh_q, HOUR_TOP);
          SET_M: mm_d = add_button ? bcd_inc(mm_q, MS_TOP) : bcd_dec(mm_q, MS_TOP);
          SET_S: ss_d = add_button ? bcd_inc(ss_q, MS_TOP) : bcd_dec(ss_q, MS_TOP);
`ifdef WATCH_MULTIMODE_ALARM_EN
          SET_AH: ah_d = add_button ? bcd_inc(ah_q, HOUR_TOP) : bcd_dec(ah_q, HOUR_TOP);
          SET_AM: am_d = add_button ? bcd_inc(am_q, MS_TOP) : bcd_dec(am_q, MS_TOP);
`endif
          TMR: begin
            if (!run_q) tm_d = add_button ? bcd_inc(tm_q, MS_TOP) : bcd_dec(tm_q, MS_TOP);
            else tm_d = tm_q;
          end
          default: state_d = state_q;
        endcase
      end else begin
        state_d = state_q;
      end
      if (start_button && state_q == TMR) begin
        if (run_q) run_d = 1'b0;
        else run_d = (tm_q != 8'h00 || ts_q != 8'h00);
      end else begin
        run_d = run_q;
      end
    end

    if (sec_s && run_q) begin
      ts_d = bcd_dec(ts_q, MS_TOP);
      tm_d = (ts_q == 8'h00) ? bcd_dec(tm_q, MS_TOP) : tm_q;
      if (tm_q == 8'h00 && ts_q == 8'h01) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      done_d = 1'b0;
    end

`ifdef WATCH_MULTIMODE_ALARM_EN
    btn_s   = mode_button | add_button | sub_button | start_button;
    clear_s = ring_q & btn_s;
    match_s = ({hh_d, mm_d, ss_d} == {ah_q, am_q, 8'h00});
    ring_d  = !clear_s && (ring_q || (armed_q && sec_s && match_s));
    armed_d = (mode_button && state_q == SET_S) || (armed_q && !clear_s);
`endif

    en_h_s = (state_q == SET_H) ? pulse_blink : 1'b1;
    en_m_s = (state_q == SET_M) ? pulse_blink : 1'b1;
    en_s_s = (state_q == SET_S) ? pulse_blink : 1'b1;
    en_t_s = run_q ? 1'b1 : pulse_blink;
    case (state_q)
      TMR: disp_d = {SEP, SEP, SEP, digit(en_t_s, tm_q[7:4]), digit(en_t_s, tm_q[3:0]),
                     SEP, digit(en_t_s, ts_q[7:4]), digit(en_t_s, ts_q[3:0])};
`ifdef WATCH_MULTIMODE_ALARM_EN
      SET_AH, SET_AM: begin
        en_h_s = (state_q == SET_AH) ? pulse_blink : 1'b1;
        en_m_s = (state_q == SET_AM) ? pulse_blink : 1'b1;
        disp_d = {digit(en_h_s, ah_q[7:4]), digit(en_h_s, ah_q[3:0]), SEP,
                  digit(en_m_s, am_q[7:4]), digit(en_m_s, am_q[3:0]), SEP,
                  digit(1'b1, 4'd0), digit(1'b1, 4'd0)};
      end
`endif
      default: disp_d = {digit(en_h_s, hh_q[7:4]), digit(en_h_s, hh_q[3:0]), SEP,
                         digit(en_m_s, mm_q[7:4]), digit(en_m_s, mm_q[3:0]), SEP,
                         digit(en_s_s, ss_q[7:4]), digit(en_s_s, ss_q[3:0])};
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hh_q <= 8'h00; mm_q <= 8'h00; ss_q <= 8'h00; tm_q <= 8'h00; ts_q <= 8'h00;
      pre_q <= {PW{1'b0}};
      run_q <= 1'b0; done_q <= 1'b0; ring_q <= 1'b0;
      disp_q <= {8{SEP}};
`ifdef WATCH_MULTIMODE_ALARM_EN
      ah_q <= 8'h00; am_q <= 8'h00; armed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hh_q <= hh_d; mm_q <= mm_d; ss_q <= ss_d; tm_q <= tm_d; ts_q <= ts_d;
      pre_q <= pre_d;
      run_q <= run_d; done_q <= done_d; ring_q <= ring_d;
      disp_q <= disp_d;
`ifdef WATCH_MULTIMODE_ALARM_EN
      ah_q <= ah_d; am_q <= am_d; armed_q <= armed_d;
`endif
    end
  end

  assign {d8, d7, d6, d5, d4, d3, d2, d1} = disp_q;
  assign timer_done = done_q;
  assign alarm_ring = ring_q;
endmodule

// File: tb/tb_watch_multimode.sv
// Scoreboard bench: two watch instances (23h/1 tick and 11h/4 ticks) share the stimulus and are
// compared every cycle against a seconds-of-day model of the watch.
module tb_watch_multimode;
  localparam int HA = 23, TA = 1, HB = 11, TB = 4;
  localparam int M_RUN = 0, M_SH = 1, M_SM = 2, M_SS = 3, M_AH = 4, M_AM = 5, M_TMR = 6;
  localparam logic [47:0] RST_DISP = {8{6'b000001}};

  logic clock = 1'b0, reset = 1'b1, pulse_tick = 1'b0, pulse_blink = 1'b1;
  logic mode_button = 1'b0, add_button = 1'b0, sub_button = 1'b0, start_button = 1'b0;
  logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8, b1, b2, b3, b4, b5, b6, b7, b8;
  logic a_done, a_ring, b_done, b_ring;

  always #5 clock = ~clock;

  watch_multimode #(.MAX_HOUR(HA), .TICKS_PER_SEC(TA)) u_a (
    .clock(clock), .reset(reset), .pulse_tick(pulse_tick), .pulse_blink(pulse_blink),
    .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
    .start_button(start_button), .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6),
    .d7(a7), .d8(a8), .timer_done(a_done), .alarm_ring(a_ring));

  watch_multimode #(.MAX_HOUR(HB), .TICKS_PER_SEC(TB)) u_b (
    .clock(clock), .reset(reset), .pulse_tick(pulse_tick), .pulse_blink(pulse_blink),
    .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
    .start_button(start_button), .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6),
    .d7(b7), .d8(b8), .timer_done(b_done), .alarm_ring(b_ring));

  typedef struct {
    int mode; int tod; int tmr; bit running; int pre; int al_h; int al_m; bit armed; bit ring;
  } mdl_t;

  mdl_t ma, mb;
  logic [49:0] qa[$], qb[$];
  int checks = 0, failures = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_RUN; m.tod = 0; m.tmr = 0; m.running = 1'b0; m.pre = 0;
    m.al_h = 0; m.al_m = 0; m.armed = 1'b0; m.ring = 1'b0;
    return m;
  endfunction

  function automatic int next_mode(input int md);
    case (md)
      M_RUN: return M_SH;
      M_SH:  return M_SM;
      M_SM:  return M_SS;
`ifdef WATCH_MULTIMODE_ALARM_EN
      M_SS:  return M_AH;
      M_AH:  return M_AM;
      M_AM:  return M_TMR;
`else
      M_SS:  return M_TMR;
`endif
      default: return M_RUN;
    endcase
  endfunction

  function automatic int wrap(input int v, input int n);
    return ((v % n) + n) % n;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int maxh, input int tps, input bit tk,
                                input bit md, input bit ad, input bit sb, input bit st,
                                output bit done);
    mdl_t n;
    bit sec, clr;
    int d, h, mi, s;
    n = m; done = 1'b0; sec = 1'b0;
    if (m.mode == M_RUN || m.mode == M_TMR) begin
      if (tk) begin
        if (m.pre + 1 == tps) begin n.pre = 0; sec = 1'b1; end
        else n.pre = m.pre + 1;
      end
    end else n.pre = 0;
    h = m.tod / 3600; mi = (m.tod / 60) % 60; s = m.tod % 60;
    if (md) n.mode = next_mode(m.mode);
    else begin
      if (ad != sb) begin
        d = ad ? 1 : -1;
        case (m.mode)
          M_SH:  n.tod = wrap(h + d, maxh + 1) * 3600 + mi * 60 + s;
          M_SM:  n.tod = h * 3600 + wrap(mi + d, 60) * 60 + s;
          M_SS:  n.tod = h * 3600 + mi * 60 + wrap(s + d, 60);
          M_AH:  n.al_h = wrap(m.al_h + d, maxh + 1);
          M_AM:  n.al_m = wrap(m.al_m + d, 60);
          M_TMR: if (!m.running) n.tmr = wrap(m.tmr / 60 + d, 60) * 60 + m.tmr % 60;
          default: ;
        endcase
      end
      if (st && m.mode == M_TMR) begin
        if (m.running) n.running = 1'b0;
        else if (m.tmr != 0) n.running = 1'b1;
      end
    end
    if (sec) n.tod = (m.tod + 1) % ((maxh + 1) * 3600);
    if (sec && m.running) begin
      n.tmr = m.tmr - 1;
      if (n.tmr == 0) begin n.running = 1'b0; done = 1'b1; end
    end
    clr = m.ring && (md || ad || sb || st);
    if (clr) begin n.ring = 1'b0; n.armed = 1'b0; end
    else if (m.armed && sec && n.tod == m.al_h * 3600 + m.al_m * 60) n.ring = 1'b1;
    if (md && next_mode(m.mode) == M_AH) n.armed = 1'b1;
    return n;
  endfunction

  function automatic logic [5:0] dg(input bit en, input int v);
    return {en, 4'(v), 1'b0};
  endfunction

  function automatic logic [47:0] disp(input mdl_t m, input bit bl);
    logic [5:0] sp;
    bit e1, e2, e3;
    int h, mi, s;
    sp = 6'b000001;
    if (m.mode == M_TMR) begin
      e1 = m.running ? 1'b1 : bl;
      mi = m.tmr / 60; s = m.tmr % 60;
      return {sp, sp, sp, dg(e1, mi / 10), dg(e1, mi % 10), sp, dg(e1, s / 10), dg(e1, s % 10)};
    end
    if (m.mode == M_AH || m.mode == M_AM) begin
      e1 = (m.mode == M_AH) ? bl : 1'b1;
      e2 = (m.mode == M_AM) ? bl : 1'b1;
      return {dg(e1, m.al_h / 10), dg(e1, m.al_h % 10), sp, dg(e2, m.al_m / 10),
              dg(e2, m.al_m % 10), sp, dg(1'b1, 0), dg(1'b1, 0)};
    end
    h = m.tod / 3600; mi = (m.tod / 60) % 60; s = m.tod % 60;
    e1 = (m.mode == M_SH) ? bl : 1'b1;
    e2 = (m.mode == M_SM) ? bl : 1'b1;
    e3 = (m.mode == M_SS) ? bl : 1'b1;
    return {dg(e1, h / 10), dg(e1, h % 10), sp, dg(e2, mi / 10), dg(e2, mi % 10), sp,
            dg(e3, s / 10), dg(e3, s % 10)};
  endfunction

  task automatic chk(input string nm, input logic [49:0] act, input logic [49:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, queue what each DUT must show after the next rise.
  task automatic cyc(input bit tk, input bit md, input bit ad, input bit sb, input bit st,
                     input bit bl);
    bit da, db;
    logic [47:0] ea, eb;
    @(negedge clock);
    pulse_tick = tk; mode_button = md; add_button = ad; sub_button = sb;
    start_button = st; pulse_blink = bl;
    ea = disp(ma, bl);
    eb = disp(mb, bl);
    ma = step(ma, HA, TA, tk, md, ad, sb, st, da);
    mb = step(mb, HB, TB, tk, md, ad, sb, st, db);
    qa.push_back({ea, da, ma.ring});
    qb.push_back({eb, db, mb.ring});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 8 && ma.mode != target; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    pulse_tick = 1'b0; mode_button = 1'b0; add_button = 1'b0; sub_button = 1'b0;
    start_button = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("reset_a", {a8, a7, a6, a5, a4, a3, a2, a1, a_done, a_ring}, {RST_DISP, 2'b00});
      chk("reset_b", {b8, b7, b6, b5, b4, b3, b2, b1, b_done, b_ring}, {RST_DISP, 2'b00});
    end
    reset = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
  endtask

  // Monitor: compare each DUT against the oldest queued expectation just after every rising edge.
  initial begin
    logic [49:0] ev;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && qa.size() > 0) begin
        ev = qa.pop_front();
        chk("dut_a_outputs", {a8, a7, a6, a5, a4, a3, a2, a1, a_done, a_ring}, ev);
      end
      if (!reset && qb.size() > 0) begin
        ev = qb.pop_front();
        chk("dut_b_outputs", {b8, b7, b6, b5, b4, b3, b2, b1, b_done, b_ring}, ev);
      end
    end
  end

  initial begin
    int r, dcnt;
    ma = mdl_reset();
    mb = mdl_reset();
    do_reset();

    // 23:59:59 -> 00:00:00 on the 1-tick instance
    goto(M_SH); cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1); cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1); cyc(0, 0, 0, 1, 0, 1);
    goto(M_RUN);
    cyc(1, 0, 0, 0, 0, 1); idle(2);
    chk("rollover_disp", {2'b00, a8, a7, a6, a5, a4, a3, a2, a1},
        {2'b00, 6'h20, 6'h20, 6'h01, 6'h20, 6'h20, 6'h01, 6'h20, 6'h20});

    // hour wrap at MAX_HOUR=11 in both directions
    do_reset();
    goto(M_SH); cyc(0, 0, 0, 1, 0, 1); idle(2);
    chk("hour_wrap_down", {38'd0, b8, b7}, {38'd0, 6'h22, 6'h22});
    cyc(0, 0, 1, 0, 0, 1); idle(2);
    chk("hour_wrap_up", {38'd0, b8, b7}, {38'd0, 6'h20, 6'h20});

    // prescaler counting and clearing while setting
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1);
    goto(M_SH); goto(M_RUN);
    cyc(1, 0, 0, 0, 0, 1); idle(2);

    // add+sub cancel; mode beats add
    goto(M_SM); cyc(0, 0, 1, 1, 0, 1); cyc(0, 1, 1, 0, 0, 1); idle(2);
    goto(M_RUN);

    // 3-minute countdown ends with a single timer_done pulse
    do_reset();
    goto(M_TMR);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    dcnt = 0;
    for (int i = 0; i < 186; i++) begin
      cyc(1, 0, 0, 0, 0, $urandom_range(0, 1) == 1);
      if (a_done) dcnt++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      if (a_done) dcnt++;
    end
    chk("timer_done_pulses", 50'(dcnt), 50'd1);

    // reset in the middle of a countdown discards it
    do_reset();
    goto(M_TMR); cyc(0, 0, 1, 0, 0, 1); cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 58; i++) cyc(1, 0, 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 1);

`ifdef WATCH_MULTIMODE_ALARM_EN
    // alarm 07:30 fires at 07:29:59 + 1 s and clears on a button
    do_reset();
    goto(M_SH); for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 1);
    goto(M_SM); for (int i = 0; i < 29; i++) cyc(0, 0, 1, 0, 0, 1);
    goto(M_SS); for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0, 1);
    goto(M_AH); for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 1);
    goto(M_AM); for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0, 1);
    goto(M_RUN);
    cyc(1, 0, 0, 0, 0, 1); idle(1);
    chk("alarm_ring_set", {49'd0, a_ring}, 50'd1);
    cyc(0, 0, 1, 0, 0, 1); idle(1);
    chk("alarm_ring_clear", {49'd0, a_ring}, 50'd0);
`endif

    // random traffic, at most one kind of button action per cycle
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 23);
      cyc($urandom_range(0, 1) == 1, r == 0, r == 1 || r == 4, r == 2 || r == 4, r == 3,
          $urandom_range(0, 1) == 1);
    end
    idle(2);
    @(posedge clock);
    #2;
    chk("scoreboard_drain", 50'(qa.size() + qb.size()), 50'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watch_multimode.md
WATCH_MULTIMODE -- requirements
Module: watch_multimode

Interface
REQ-001 Parameter MAX_HOUR, 23, highest hour value before wrap to 00; legal range 1..99.
REQ-002 Parameter TICKS_PER_SEC, 1, pulse_tick events per one-second advance; legal range 1..1000.
REQ-003 clock  in  1  system clock; reset is asynchronous, active-high; clock is clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 pulse_tick  in  1  single-cycle time-base pulse.
REQ-006 pulse_blink  in  1  blink level (~500 ms high/low).
REQ-007 mode_button, add_button, sub_button, start_button  in  1 each  debounced single-cycle pulses.
REQ-008 d1..d8  out  6 each  display digit {enable, bcd[3:0], dp}; d8 leftmost.
REQ-009 timer_done  out  1  one-cycle pulse when countdown reaches 00:00.
REQ-010 alarm_ring  out  1  alarm active level.

Function
REQ-011 The block SHALL hold time as BCD HH:MM:SS and a countdown timer as BCD MM:SS.
REQ-012 States SHALL be RUN, SET_H, SET_M, SET_S, TMR; mode_button advances RUN->SET_H->SET_M->SET_S->TMR->RUN (alarm states per REQ-027).
REQ-013 In RUN and TMR, a prescaler SHALL count pulse_tick; on the TICKS_PER_SEC-th tick it clears and time advances one second in the same cycle.
REQ-014 Time advance SHALL carry SS 59->00, MM 59->00, HH MAX_HOUR->00; MAX_HOUR:59:59 +1 s -> 00:00:00.
REQ-015 In SET_H/SET_M/SET_S, time SHALL be frozen and the prescaler held at 0; add_button +1, sub_button -1 on the selected field with wrap (hours 0..MAX_HOUR, min/sec 0..59), no carry into other fields.
REQ-016 In TMR, add_button/sub_button SHALL adjust timer minutes +/-1 (wrap 0..59) only while the timer is stopped; start_button toggles running; start with timer 00:00 is ignored.
REQ-017 A running timer SHALL decrement one second per prescaled second in every state; on reaching 00:00 it stops and timer_done pulses for exactly one cycle.
REQ-018 mode_button SHALL take priority over add/sub/start in the same cycle; add and sub together SHALL cause no change.
REQ-019 RUN/SET display: d8,d7 hours; d5,d4 minutes; d2,d1 seconds; d6,d3 = 6'b000001; enable bit = 1 except the field being set, whose enable = pulse_blink.
REQ-020 TMR display: d8,d7,d6,d3 = 6'b000001; d5,d4 timer minutes; d2,d1 timer seconds; enable = pulse_blink when stopped, 1 when running.
REQ-021 d1..d8 SHALL be registered, reflecting state/counters of the previous cycle (1-cycle latency).

Reset
REQ-022 On reset: state RUN, time 00:00:00, timer 00:00 stopped, prescaler 0, alarm 00:00 disarmed.
REQ-023 On reset: d1..d8 = 6'b000001, timer_done = 0, alarm_ring = 0.
REQ-024 Reset asserted mid-adjust or mid-countdown SHALL discard all pending values with no timer_done pulse.

Configuration
REQ-025 Macro WATCH_MULTIMODE_ALARM_EN SHALL compile the alarm feature in.
REQ-026 Without it, alarm_ring SHALL be constant 0 and the state sequence is per REQ-012.
REQ-027 With it, states SET_AH and SET_AM SHALL be inserted between SET_S and TMR, adjusting alarm hours/minutes as REQ-015 and displayed as HH:MM:00 with the edited field blinking; entering SET_AH arms the alarm.
REQ-028 With it, alarm_ring SHALL set when armed and time advances to alarm HH:MM:00, and clear (and disarm) on any button pulse or reset.

Verification
REQ-029 TICKS_PER_SEC=1, time 23:59:59, one pulse_tick -> time 00:00:00, displays d8..d1 bcd 0,0,-,0,0,-,0,0 one cycle later.
REQ-030 MAX_HOUR=11, SET_H at 00, sub_button -> 11; add_button -> 00; minutes/seconds unchanged.
REQ-031 TICKS_PER_SEC=4, RUN, 8 pulse_tick -> seconds +2; enter SET_H after 3 ticks, exit, 1 tick -> no advance.
REQ-032 TMR, 3x add_button, start_button, 180 prescaled seconds -> timer 00:00, timer_done high exactly one cycle, timer stopped.
REQ-033 add_button and sub_button same cycle in SET_M -> no change; mode_button+add same cycle -> state SET_S, minutes unchanged.
REQ-034 WATCH_MULTIMODE_ALARM_EN, alarm 07:30, time 07:29:59, one second -> alarm_ring=1; add_button -> alarm_ring=0.
